// File: rtl/iob2axi_burst_ctrl.sv
// -----------------------------------------------------------------------------
// iob2axi_burst_ctrl
//
// Upstream sequencer for the iob2axi bridge. A DMA command (direction, byte
// address, word count) is split into AXI4 bursts of at most 2**AXI_LEN_W
// beats that never cross a 4 KiB page. Each burst is started on the bridge
// control interface (run/direction/length) and its beats are moved over the
// bridge's native slave interface.
//
// Ports
//   clk_i, rst_i                 clock (rising edge), asynchronous reset (active-low)
//   cmd_valid_i/cmd_ready_o      command handshake; cmd_dir_i, cmd_addr_i, cmd_cnt_i
//   in_valid_i/in_data_i/in_ready_o     write-data stream (to memory)
//   out_valid_o/out_data_o/out_ready_i  read-data stream (from memory)
//   run_o, direction_o, length_o        bridge control (length = beats-1)
//   iob2axi_ready_i, iob2axi_error_i    bridge idle / error status
//   m_valid_o, m_addr_o, m_wdata_o, m_wstrb_o, m_rdata_i, m_ready_i
//                                       native request/response to the bridge
//   busy_o, done_o, err_o               command status
// -----------------------------------------------------------------------------
module iob2axi_burst_ctrl #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int AXI_LEN_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_dir_i,
    input  logic [ADDR_W-1:0]    cmd_addr_i,
    input  logic [CNT_W-1:0]     cmd_cnt_i,
    input  logic                 in_valid_i,
    input  logic [DATA_W-1:0]    in_data_i,
    output logic                 in_ready_o,
    output logic                 out_valid_o,
    output logic [DATA_W-1:0]    out_data_o,
    input  logic                 out_ready_i,
    output logic                 run_o,
    output logic                 direction_o,
    output logic [AXI_LEN_W-1:0] length_o,
    input  logic                 iob2axi_ready_i,
    input  logic                 iob2axi_error_i,
    output logic                 m_valid_o,
    output logic [ADDR_W-1:0]    m_addr_o,
    output logic [DATA_W-1:0]    m_wdata_o,
    output logic [DATA_W/8-1:0]  m_wstrb_o,
    input  logic [DATA_W-1:0]    m_rdata_i,
    input  logic                 m_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int NB     = DATA_W / 8;
    localparam int NB_LOG = $clog2(NB);
    localparam int RW     = CNT_W + 1;      // remaining-word counter width
    localparam int BW     = AXI_LEN_W + 1;  // beat counter width (up to 2**AXI_LEN_W)

    localparam logic [RW-1:0]     MAX_BEATS  = {{(RW-BW){1'b0}}, 1'b1, {AXI_LEN_W{1'b0}}};
    localparam logic [12:0]       PAGE_BYTES = 13'h1000;
    localparam logic [ADDR_W-1:0] ADDR_MASK  = ~ADDR_W'(NB - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_XFER  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    logic [2:0]           state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 dir_q, dir_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [RW-1:0]        rem_q, rem_d;
    logic [BW-1:0]        beats_q, beats_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [AXI_LEN_W-1:0] length_q, length_d;
    logic                 run_q, run_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 err_seen_q, err_seen_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;

    logic                 xfer_s;
    logic                 rd_free_s;
    logic                 m_valid_s;
    logic                 beat_fire_s;
    logic                 err_now_s;
    logic [12:0]          room_s;
    logic [RW-1:0]        lim_s;
    logic [RW-1:0]        beats_s;

    // Native-side handshake: the run cycle itself carries no beat.
    always_comb begin
        xfer_s      = (state_q == S_XFER) && !run_q;
        rd_free_s   = !out_valid_q || out_ready_i;
        m_valid_s   = xfer_s ? (dir_q ? in_valid_i : rd_free_s) : 1'b0;
        beat_fire_s = m_valid_s && m_ready_i;
        err_now_s   = err_seen_q ||
                      (((state_q == S_XFER) || (state_q == S_DRAIN)) && iob2axi_error_i);
        // Words left in the current 4 KiB page, then clamp by count and burst limit.
        room_s      = (PAGE_BYTES - {1'b0, addr_q[11:0]}) >> NB_LOG;
        lim_s       = (rem_q < MAX_BEATS) ? rem_q : MAX_BEATS;
        beats_s     = (RW'(room_s) < lim_s) ? RW'(room_s) : lim_s;
    end

    // Next-state logic for the sequencer and all registered outputs.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        beats_d     = beats_q;
        bcnt_d      = bcnt_q;
        length_d    = length_q;
        run_d       = 1'b0;
        err_d       = err_q;
        err_seen_d  = err_now_s;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        // Read output register: capture a beat, or release it on consumption.
        if (beat_fire_s && !dir_q) begin
            out_data_d  = m_rdata_i;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    dir_d   = cmd_dir_i;
                    addr_d  = cmd_addr_i & ADDR_MASK;
                    rem_d   = {1'b0, cmd_cnt_i};
                    err_d   = 1'b0;
                    state_d = (cmd_cnt_i == {CNT_W{1'b0}}) ? S_FIN : S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                beats_d    = BW'(beats_s);
                bcnt_d     = BW'(beats_s);
                length_d   = AXI_LEN_W'(beats_s - {{(RW-1){1'b0}}, 1'b1});
                err_seen_d = 1'b0;
                state_d    = S_START;
            end
            S_START: begin
                if (iob2axi_ready_i) begin
                    run_d   = 1'b1;
                    state_d = S_XFER;
                end else begin
                    state_d = S_START;
                end
            end
            S_XFER: begin
                if (beat_fire_s) begin
                    bcnt_d  = bcnt_q - {{AXI_LEN_W{1'b0}}, 1'b1};
                    state_d = (bcnt_q == {{AXI_LEN_W{1'b0}}, 1'b1}) ? S_DRAIN : S_XFER;
                end else begin
                    state_d = S_XFER;
                end
            end
            S_DRAIN: begin
                // Wait for the bridge to finish (write response) and the last
                // read beat to leave the output register.
                if (iob2axi_ready_i && !out_valid_q) begin
                    addr_d = addr_q + (ADDR_W'(beats_q) << NB_LOG);
                    rem_d  = rem_q - RW'(beats_q);
                    if (err_now_s) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else if (rem_d == {RW{1'b0}}) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        done_d      = (state_q == S_FIN);
        // busy covers the done cycle, which follows the FIN state.
        busy_d      = (state_d != S_IDLE) || (state_q == S_FIN);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            dir_q       <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            rem_q       <= {RW{1'b0}};
            beats_q     <= {BW{1'b0}};
            bcnt_q      <= {BW{1'b0}};
            length_q    <= {AXI_LEN_W{1'b0}};
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_seen_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            dir_q       <= dir_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            beats_q     <= beats_d;
            bcnt_q      <= bcnt_d;
            length_q    <= length_d;
            run_q       <= run_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_seen_q  <= err_seen_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign in_ready_o  = (xfer_s && dir_q) ? m_ready_i : 1'b0;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign run_o       = run_q;
    assign direction_o = dir_q;
    assign length_o    = length_q;
    assign m_valid_o   = m_valid_s;
    assign m_addr_o    = addr_q;
    assign m_wdata_o   = (xfer_s && dir_q) ? in_data_i : {DATA_W{1'b0}};
    assign m_wstrb_o   = ((state_q == S_XFER) && dir_q) ? {NB{1'b1}} : {NB{1'b0}};
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
